riscv_dcache: RTL and testbench

Blocking, direct-mapped, write-through, no-write-allocate data cache between the RISCV150 core's dcache port and the external memory arbiter.
- Consumes core requests: dcache_addr, dcache_re, dcache_we, dcache_din.
- Returns dcache_dout in the cycle after the request, matching the core's block-RAM load timing.
- Asserts stall to freeze the whole pipeline on a miss or a write-through.
- Issues line refills and masked word writes to memory over a valid/ready request plus valid response interface.

---
 rtl/riscv_dcache.sv | 194 +++++++++++++++++++
 tb/tb_riscv_dcache.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_dcache.sv
// Blocking, direct-mapped, write-through, no-write-allocate data cache for the RISCV150 core.
// Define DCACHE_STATS_EN to add load-hit / load-miss / store event counters.
module riscv_dcache #(
  parameter int LINES      = 64,
  parameter int LINE_WORDS = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  dcache_addr,
  input  logic         dcache_re,
  input  logic [3:0]   dcache_we,
  input  logic [31:0]  dcache_din,
  output logic [31:0]  dcache_dout,
  output logic         stall,
  output logic         mem_req_valid,
  input  logic         mem_req_ready,
  output logic         mem_req_rnw,
  output logic [27:0]  mem_req_addr,
  output logic [127:0] mem_req_data,
  output logic [15:0]  mem_req_mask,
  input  logic         mem_resp_valid,
  input  logic [127:0] mem_resp_data
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]  stat_hits,
  output logic [31:0]  stat_misses,
  output logic [31:0]  stat_writes
`endif
);

  localparam int IDX_W  = $clog2(LINES);
  localparam int TAG_W  = 28 - IDX_W;
  localparam int LINE_W = LINE_WORDS * 32;
  localparam int BYTES  = LINE_W / 8;

  typedef enum logic [2:0] {IDLE, COMPARE, MISS_REQ, MISS_WAIT, WR_REQ} state_t;
  state_t state, state_nx;

  logic [LINE_W-1:0] data_arr [LINES];
  logic [TAG_W-1:0]  tag_arr  [LINES];
  logic [LINES-1:0]  valid;

  logic [27:0]       r_line;
  logic [1:0]        r_off;
  logic              r_re;
  logic [3:0]        r_we;
  logic [31:0]       r_din;
  logic [LINE_W-1:0] rd_line;
  logic [TAG_W-1:0]  rd_tag;
  logic              rd_valid;
  logic [31:0]       dout_q, dout_nx;

  logic              req, cap, hit, is_store, is_load, fill, merge;
  logic [IDX_W-1:0]  a_idx, r_idx;
  logic [TAG_W-1:0]  r_tag;
  logic [BYTES-1:0]  lane_mask;
  logic [LINE_W-1:0] merged;
  logic [31:0]       hit_word, resp_word;
  logic              unused_addr_lsb;

  assign unused_addr_lsb = ^dcache_addr[1:0];

  assign req       = dcache_re | (|dcache_we);
  assign a_idx     = dcache_addr[4 +: IDX_W];
  assign r_idx     = r_line[IDX_W-1:0];
  assign r_tag     = r_line[27 -: TAG_W];
  assign hit       = rd_valid && (rd_tag == r_tag);
  assign is_store  = |r_we;
  assign is_load   = !is_store && r_re;
  assign lane_mask = BYTES'(r_we) << {r_off, 2'b00};
  assign hit_word  = rd_line[{r_off, 5'b0} +: 32];
  assign resp_word = mem_resp_data[{r_off, 5'b0} +: 32];
  // A load hit frees the COMPARE slot, so the next request is captured in the same cycle.
  assign cap       = (state == IDLE) || (state == COMPARE && is_load && hit);

  always_comb begin
    merged = rd_line;
    for (int b = 0; b < BYTES; b++)
      if (lane_mask[b]) merged[b*8 +: 8] = r_din[(b%4)*8 +: 8];
  end

  always_comb begin
    state_nx      = state;
    stall         = 1'b0;
    dout_nx       = dout_q;
    fill          = 1'b0;
    merge         = 1'b0;
    mem_req_valid = 1'b0;
    mem_req_rnw   = 1'b1;
    mem_req_addr  = '0;
    mem_req_data  = '0;
    mem_req_mask  = '0;
    case (state)
      IDLE: if (req) state_nx = COMPARE;
      COMPARE: begin
        if (is_store) begin
          stall    = 1'b1;
          merge    = hit;
          state_nx = WR_REQ;
        end else if (is_load && hit) begin
          dout_nx  = hit_word;
          state_nx = req ? COMPARE : IDLE;
        end else if (is_load) begin
          stall    = 1'b1;
          state_nx = MISS_REQ;
        end else begin
          state_nx = IDLE;
        end
      end
      MISS_REQ: begin
        stall         = 1'b1;
        mem_req_valid = 1'b1;
        mem_req_addr  = r_line;
        if (mem_req_ready) state_nx = MISS_WAIT;
      end
      MISS_WAIT: begin
        if (mem_resp_valid) begin
          fill     = 1'b1;
          dout_nx  = resp_word;
          state_nx = IDLE;
        end else begin
          stall = 1'b1;
        end
      end
      WR_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_rnw   = 1'b0;
        mem_req_addr  = r_line;
        mem_req_data  = {LINE_WORDS{r_din}};
        mem_req_mask  = lane_mask;
        if (mem_req_ready) state_nx = IDLE;
        else               stall    = 1'b1;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign dcache_dout = dout_nx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      valid    <= '0;
      dout_q   <= '0;
      r_line   <= '0;
      r_off    <= '0;
      r_re     <= 1'b0;
      r_we     <= '0;
      r_din    <= '0;
      rd_valid <= 1'b0;
    end else begin
      state  <= state_nx;
      dout_q <= dout_nx;
      if (fill) valid[r_idx] <= 1'b1;
      if (cap) begin
        r_line   <= dcache_addr[31:4];
        r_off    <= dcache_addr[3:2];
        r_re     <= dcache_re;
        r_we     <= dcache_we;
        r_din    <= dcache_din;
        rd_valid <= valid[a_idx];
      end
    end
  end

  // Arrays carry no reset; the valid bits alone decide whether their contents mean anything.
  always_ff @(posedge clk) begin
    if (fill) begin
      data_arr[r_idx] <= mem_resp_data;
      tag_arr[r_idx]  <= r_tag;
    end else if (merge) begin
      data_arr[r_idx] <= merged;
    end
    if (cap) begin
      rd_line <= data_arr[a_idx];
      rd_tag  <= tag_arr[a_idx];
    end
  end

`ifdef DCACHE_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_hits   <= '0;
      stat_misses <= '0;
      stat_writes <= '0;
    end else if (state == COMPARE) begin
      if (is_store)           stat_writes <= stat_writes + 32'd1;
      else if (is_load && hit) stat_hits  <= stat_hits + 32'd1;
      else if (is_load)       stat_misses <= stat_misses + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_riscv_dcache.sv
// Scoreboard bench for riscv_dcache: driver + reference model push expectations,
// a monitor pops and compares load data and memory requests; a memory model answers refills.
module tb_riscv_dcache;
  localparam int LINES = 64;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  dcache_addr, dcache_din, dcache_dout;
  logic         dcache_re, stall;
  logic [3:0]   dcache_we;
  logic         mem_req_valid, mem_req_ready, mem_req_rnw;
  logic [27:0]  mem_req_addr;
  logic [127:0] mem_req_data, mem_resp_data;
  logic [15:0]  mem_req_mask;
  logic         mem_resp_valid;

  riscv_dcache #(.LINES(LINES)) dut (
    .clk(clk), .rst(rst),
    .dcache_addr(dcache_addr), .dcache_re(dcache_re), .dcache_we(dcache_we),
    .dcache_din(dcache_din), .dcache_dout(dcache_dout), .stall(stall),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_rnw(mem_req_rnw),
    .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data), .mem_req_mask(mem_req_mask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
  );

  always #5 clk = ~clk;

  typedef struct { bit load; bit hit; logic [31:0] data; } exp_t;
  typedef struct { bit rnw; logic [27:0] addr; logic [127:0] data; logic [15:0] mask; } mreq_t;

  exp_t         exp_q[$];
  mreq_t        mreq_q[$];
  logic [127:0] mem [logic [27:0]];
  bit           cvalid [LINES];
  logic [27:0]  cline  [LINES];
  int           n_cmp = 0, n_bad = 0;
  bit           hold_ready = 0, resp_hold = 0;
  int           pulse_cnt = 0;
  logic         stall_d = 1'b0;

  always @(posedge clk) stall_d <= stall;

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic bail(input string why);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: bound expired before the expected event", why);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  endtask

  function automatic void touch(input logic [27:0] la);
    if (!mem.exists(la)) mem[la] = {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Reference: memory is always current (write-through), cache only tracks which line each index holds.
  task automatic model_accept(input logic [31:0] a, input logic [3:0] we, input logic [31:0] din);
    logic [27:0]  la;
    logic [127:0] ln;
    int           off, idx;
    exp_t         e;
    mreq_t        m;
    la  = a[31:4];
    off = int'(a[3:2]);
    idx = int'(la) % LINES;
    touch(la);
    if (we != 4'd0) begin
      m.rnw  = 1'b0;
      m.addr = la;
      m.data = {4{din}};
      m.mask = 16'(we) << (4 * off);
      ln = mem[la];
      for (int b = 0; b < 4; b++)
        if (we[b]) ln[off*32 + b*8 +: 8] = din[b*8 +: 8];
      mem[la] = ln;
      mreq_q.push_back(m);
      e.load = 1'b0; e.hit = 1'b0; e.data = '0;
    end else begin
      e.load = 1'b1;
      e.hit  = cvalid[idx] && (cline[idx] == la);
      if (!e.hit) begin
        m.rnw = 1'b1; m.addr = la; m.data = '0; m.mask = '0;
        mreq_q.push_back(m);
        cvalid[idx] = 1'b1;
        cline[idx]  = la;
      end
      ln     = mem[la];
      e.data = ln[off*32 +: 32];
    end
    exp_q.push_back(e);
  endtask

  // Called just after a posedge; returns just after the posedge following acceptance.
  task automatic issue(input logic [31:0] a, input logic r, input logic [3:0] w, input logic [31:0] d);
    int waited;
    bit acc;
    waited = 0;
    acc    = 1'b0;
    dcache_addr = a; dcache_re = r; dcache_we = w; dcache_din = d;
    while (!acc) begin
      @(negedge clk);
      acc = !stall && !stall_d;
      @(posedge clk);
      waited++;
      if (!acc && waited > 200) bail("accept_timeout");
    end
    model_accept(a, w, d);
    #1;
    dcache_re = 1'b0;
    dcache_we = 4'd0;
  endtask

  task automatic drain();
    int waited;
    waited = 0;
    while (exp_q.size() != 0 || mreq_q.size() != 0) begin
      @(negedge clk);
      waited++;
      if (waited > 200) bail("drain_timeout");
    end
    @(posedge clk); #1;
  endtask

  // Memory: random ready, refill 1..3 cycles after the read handshake, occasional stray responses.
  initial begin
    int          cnt, served;
    logic [27:0] la_p;
    cnt = 0; served = 0; la_p = '0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
    forever begin
      @(negedge clk);
      if (rst) cnt = 0;
      else if (mem_req_valid && mem_req_ready && mem_req_rnw) begin
        la_p = mem_req_addr;
        cnt  = $urandom_range(1, 3);
      end
      @(posedge clk); #1;
      mem_resp_valid = 1'b0;
      if (served != pulse_cnt) begin
        served++;
        mem_resp_valid = 1'b1;
        mem_resp_data  = {$urandom, $urandom, $urandom, $urandom};
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0 && !resp_hold) begin
          mem_resp_valid = 1'b1;
          mem_resp_data  = mem[la_p];
        end
      end else if (!resp_hold && $urandom_range(0, 15) == 0) begin
        mem_resp_valid = 1'b1;
        mem_resp_data  = {$urandom, $urandom, $urandom, $urandom};
      end
      mem_req_ready = !hold_ready && ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: completions, memory request contents, request stability and stall while requesting.
  initial begin
    int    wait_cyc;
    bit    pv, pr;
    mreq_t pm, m;
    exp_t  e;
    wait_cyc = 0; pv = 0; pr = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        wait_cyc = 0;
        pv = 0;
        continue;
      end
      if (exp_q.size() > 0) begin
        wait_cyc++;
        if (!stall) begin
          e = exp_q.pop_front();
          if (e.load) chk("load_data", dcache_dout, e.data);
          if (e.hit)  chk("hit_latency", wait_cyc, 1);
          wait_cyc = 0;
        end
      end
      if (pv && !pr) begin
        chk("req_hold_valid", mem_req_valid, 1'b1);
        chk("req_hold_fields", {mem_req_rnw, mem_req_addr, mem_req_mask, mem_req_data},
            {pm.rnw, pm.addr, pm.mask, pm.data});
      end
      if (mem_req_valid) begin
        if (mem_req_rnw) chk("stall_in_read_req", stall, 1'b1);
        else             chk("stall_in_write_req", stall, !mem_req_ready);
        if (mem_req_ready) begin
          if (mreq_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_mem_req: got addr %0h rnw %0b, required no request", mem_req_addr, mem_req_rnw);
          end else begin
            m = mreq_q.pop_front();
            chk("mem_rnw", mem_req_rnw, m.rnw);
            chk("mem_addr", mem_req_addr, m.addr);
            chk("mem_mask", mem_req_mask, m.mask);
            if (!m.rnw) chk("mem_data", mem_req_data, m.data);
          end
        end
      end
      pv = mem_req_valid;
      pr = mem_req_ready;
      pm.rnw = mem_req_rnw; pm.addr = mem_req_addr; pm.mask = mem_req_mask; pm.data = mem_req_data;
    end
  end

  initial begin
    logic [21:0] tags [4];
    logic [31:0] a;
    logic [3:0]  w;
    logic        r;
    int          waited;
    tags[0] = 22'h0; tags[1] = 22'h1; tags[2] = 22'h2AAAA; tags[3] = 22'h3FFFFF;
    rst = 1'b1;
    dcache_addr = '0; dcache_re = 1'b0; dcache_we = '0; dcache_din = '0;
    mem[28'h10] = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", stall, 1'b0);
    chk("rst_mem_valid", mem_req_valid, 1'b0);
    chk("rst_mem_rnw", mem_req_rnw, 1'b1);
    chk("rst_mem_addr", mem_req_addr, 28'h0);
    chk("rst_mem_data", mem_req_data, 128'h0);
    chk("rst_mem_mask", mem_req_mask, 16'h0);
    chk("rst_dout", dcache_dout, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    issue(32'h0000_0104, 1'b1, 4'd0, 32'h0);
    issue(32'h0000_0108, 1'b1, 4'd0, 32'h0);
    issue(32'h0000_0104, 1'b0, 4'b0011, 32'hAABBCCDD);
    issue(32'h0000_0104, 1'b1, 4'd0, 32'h0);
    drain();

    // Same index as 0x104, different tag; memory holds off ready for several cycles.
    hold_ready = 1;
    issue(32'h0000_0500, 1'b1, 4'd0, 32'h0);
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!mem_req_valid && waited < 20);
    for (int i = 0; i < 5; i++) begin
      chk("ready_low_valid", mem_req_valid, 1'b1);
      chk("ready_low_stall", stall, 1'b1);
      chk("ready_low_addr", mem_req_addr, 28'h50);
      @(negedge clk);
    end
    hold_ready = 0;
    @(posedge clk); #1;
    issue(32'h0000_0104, 1'b1, 4'd0, 32'h0);
    drain();

    for (int n = 0; n < 300; n++) begin
      a = {tags[$urandom_range(0, 3)], 6'($urandom_range(0, 7) | ($urandom_range(0, 1) << 4)),
           2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
      if ($urandom_range(0, 9) < 6) begin
        r = 1'b1; w = 4'd0;
      end else begin
        r = 1'($urandom_range(0, 1)); w = 4'($urandom_range(1, 15));
      end
      issue(a, r, w, $urandom);
      if ($urandom_range(0, 2) == 0)
        repeat ($urandom_range(1, 2)) begin @(posedge clk); #1; end
    end
    drain();

    // Reset while waiting for a refill, then a late response that must be ignored.
    resp_hold = 1;
    issue(32'h0000_7A40, 1'b1, 4'd0, 32'h0);
    waited = 0;
    while (mreq_q.size() != 0) begin
      @(negedge clk);
      waited++;
      if (waited > 50) bail("refill_req_timeout");
    end
    @(posedge clk); #1;
    rst = 1'b1;
    exp_q.delete();
    foreach (cvalid[i]) cvalid[i] = 1'b0;
    @(negedge clk);
    chk("midrst_stall", stall, 1'b0);
    chk("midrst_mem_valid", mem_req_valid, 1'b0);
    chk("midrst_dout", dcache_dout, 32'h0);
    pulse_cnt++;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("late_resp_stall", stall, 1'b0);
    chk("late_resp_mem_valid", mem_req_valid, 1'b0);
    resp_hold = 0;
    @(posedge clk); #1;
    issue(32'h0000_7A40, 1'b1, 4'd0, 32'h0);
    drain();

    chk("exp_q_empty", exp_q.size(), 0);
    chk("mreq_q_empty", mreq_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    bail("global_time_limit");
  end
endmodule
